// File: rtl/instr_arb_pkg.sv
// Shared types for the instruction-memory arbiter: core id width and in-flight tag.
package instr_arb_pkg;

  localparam int unsigned N_CPU_CFG = 3;
  localparam int unsigned ID_W      = (N_CPU_CFG > 1) ? $clog2(N_CPU_CFG) : 1;

  typedef logic [ID_W-1:0] cpu_id_t;

  typedef struct packed {
    logic    vld;
    cpu_id_t id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past 'last' and wraps modulo N.
module rr_arbiter #(
  parameter int unsigned N    = 3,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [N-1:0]    gnt_c,
  output logic [ID_W-1:0] gnt_id_c,
  output logic            gnt_any_c
);

  always_comb begin
    int unsigned idx;
    gnt_c     = '0;
    gnt_id_c  = '0;
    gnt_any_c = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last) + k) % N;
      if (!gnt_any_c && req[ID_W'(idx)]) begin
        gnt_any_c            = 1'b1;
        gnt_c[ID_W'(idx)]    = 1'b1;
        gnt_id_c             = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/instr_mem_arbiter.sv
// Round-robin sharing of one fixed-latency instruction ROM between N_CPU fetch ports.
// Optional per-core grant/wait counters are built when INSTR_ARB_PERF_EN is defined.
module instr_mem_arbiter
  import instr_arb_pkg::*;
#(
  parameter int unsigned N_CPU   = N_CPU_CFG,
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CPU-1:0]          cpu_req,
  input  logic [N_CPU*ADDR_W-1:0]   cpu_addr,
  output logic [N_CPU-1:0]          cpu_rsp_vld,
  output logic [DATA_W-1:0]         cpu_instr,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_rdata,
`ifdef INSTR_ARB_PERF_EN
  output logic [N_CPU*16-1:0]       perf_grant_cnt,
  output logic [N_CPU*16-1:0]       perf_wait_cnt,
`endif
  output cpu_id_t                   grant_id
);

  logic [N_CPU-1:0] pending_q, pending_d;
  cpu_id_t          last_q, last_d;
  tag_t             tag_q [LATENCY];
  tag_t             tag_d [LATENCY];

  logic [N_CPU-1:0] eligible_c;
  logic [N_CPU-1:0] gnt_c;
  logic [N_CPU-1:0] gnt_live_c;
  cpu_id_t          gnt_id_c;
  logic             gnt_any_c;

  assign eligible_c = cpu_req & ~pending_q;

  rr_arbiter #(
    .N    (N_CPU),
    .ID_W (ID_W)
  ) u_rr (
    .req       (eligible_c),
    .last      (last_q),
    .gnt_c     (gnt_c),
    .gnt_id_c  (gnt_id_c),
    .gnt_any_c (gnt_any_c)
  );

  // Memory side: a grant is suppressed while reset is held.
  always_comb begin
    mem_req    = gnt_any_c & ~rst;
    gnt_live_c = gnt_c & {N_CPU{mem_req}};
    mem_addr   = '0;
    for (int unsigned i = 0; i < N_CPU; i++) begin
      if (gnt_live_c[i]) mem_addr = mem_addr | cpu_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign grant_id = gnt_id_c;

  // Route the returning word to the core named by the oldest tag.
  always_comb begin
    cpu_rsp_vld = '0;
    cpu_instr   = '0;
    if (tag_q[LATENCY-1].vld && !rst) begin
      cpu_rsp_vld[tag_q[LATENCY-1].id] = 1'b1;
      cpu_instr                        = mem_rdata;
    end
  end

  always_comb begin
    pending_d = (pending_q & ~cpu_rsp_vld) | gnt_live_c;
    last_d    = mem_req ? gnt_id_c : last_q;
    tag_d[0].vld = mem_req;
    tag_d[0].id  = gnt_id_c;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      last_q    <= ID_W'(N_CPU - 1);
      for (int unsigned i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      last_q    <= last_d;
      for (int unsigned i = 0; i < LATENCY; i++) tag_q[i] <= tag_d[i];
    end
  end

`ifdef INSTR_ARB_PERF_EN
  logic [N_CPU*16-1:0] grant_cnt_q, grant_cnt_d;
  logic [N_CPU*16-1:0] wait_cnt_q, wait_cnt_d;

  // A wait is a cycle where the core could have been served but another core won.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    for (int unsigned i = 0; i < N_CPU; i++) begin
      grant_cnt_d[i*16 +: 16] = grant_cnt_q[i*16 +: 16] + 16'(gnt_live_c[i]);
      wait_cnt_d[i*16 +: 16]  = wait_cnt_q[i*16 +: 16]
                                + 16'(eligible_c[i] & ~gnt_live_c[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign perf_grant_cnt = grant_cnt_q;
  assign perf_wait_cnt  = wait_cnt_q;
`endif

endmodule
